// File: rtl/hweval_mpadder_chk.sv
// Evaluation harness for a start/done multi-precision adder: chained operands, golden check,
// hang timeout, pass/fail. Optional result signature folding enabled by HWEVAL_SIG_EN.
module hweval_mpadder_chk #(
  parameter int              WIDTH    = 514,
  parameter int              ITER     = 1024,
  parameter int              TIMEOUT  = 4096,
  parameter logic [WIDTH-1:0] SEED_A  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter logic [WIDTH-1:0] SEED_B  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter bit              SEED_SUB = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  output logic             dut_start,
  output logic             dut_subtract,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH:0]   dut_result,
  input  logic             dut_done,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [15:0]      err_count,
  output logic [31:0]      sig
);
  localparam int IW  = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int NSL = (WIDTH + 32) / 32;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CHECK, S_END} state_t;
  state_t state, state_nx;

  logic [WIDTH:0]  res_q, gold_q, gold;
  logic [IW-1:0]   iter_cnt;
  logic [TW-1:0]   wait_cnt;
  logic [15:0]     err_nx;
  logic            last_iter, wait_exp, accept;

  assign last_iter = (iter_cnt == IW'(ITER - 1));
  assign wait_exp  = (wait_cnt == TW'(TIMEOUT - 1));
  assign accept    = ((state == S_IDLE) || (state == S_END)) && run;
  assign gold      = dut_subtract ? ({1'b0, dut_a} - {1'b0, dut_b})
                                  : ({1'b0, dut_a} + {1'b0, dut_b});
  assign err_nx    = ((res_q != gold_q) && (err_count != 16'hFFFF)) ? err_count + 16'd1
                                                                    : err_count;

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_END: if (run) state_nx = S_LAUNCH;
      S_LAUNCH:      state_nx = S_WAIT;
      S_WAIT: begin
        if (dut_done)      state_nx = S_CHECK;
        else if (wait_exp) state_nx = S_END;
      end
      S_CHECK:       state_nx = last_iter ? S_END : S_LAUNCH;
      default:       state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    dut_start = (state == S_LAUNCH);
    busy      = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dut_a        <= SEED_A;
      dut_b        <= SEED_B;
      dut_subtract <= SEED_SUB;
      res_q        <= '0;
      gold_q       <= '0;
      iter_cnt     <= '0;
      wait_cnt     <= '0;
      err_count    <= '0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_END: if (run) begin
          dut_a        <= SEED_A;
          dut_b        <= SEED_B;
          dut_subtract <= SEED_SUB;
          iter_cnt     <= '0;
          wait_cnt     <= '0;
          err_count    <= '0;
          pass         <= 1'b0;
          fail         <= 1'b0;
          timeout      <= 1'b0;
        end
        S_WAIT: begin
          if (dut_done) begin
            res_q  <= dut_result;
            gold_q <= gold;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
            if (wait_exp) begin
              timeout <= 1'b1;
              fail    <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          // next operands come from the golden value so a faulty DUT cannot derail the sequence
          err_count    <= err_nx;
          dut_a        <= dut_b ^ gold_q[WIDTH-1:0];
          dut_b        <= gold_q[WIDTH-1:0];
          dut_subtract <= gold_q[WIDTH];
          if (last_iter) begin
            pass <= (err_nx == 16'd0);
            fail <= (err_nx != 16'd0);
          end else begin
            iter_cnt <= iter_cnt + IW'(1);
            wait_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HWEVAL_SIG_EN
  logic [NSL*32-1:0]  res_pad;
  logic [NSL:0][31:0] fold;
  logic [31:0]        sig_q;

  assign res_pad = (NSL*32)'(res_q);
  assign fold[0] = '0;
  for (genvar i = 0; i < NSL; i++) begin : g_fold
    assign fold[i+1] = fold[i] ^ res_pad[32*i +: 32];
  end

  always_ff @(posedge clk) begin
    if (!resetn || accept)   sig_q <= '0;
    else if (state == S_CHECK) sig_q <= {sig_q[30:0], sig_q[31]} ^ fold[NSL];
  end
  assign sig = sig_q;
`else
  assign sig = 32'h0;
`endif

endmodule

// File: tb/tb_hweval_mpadder_chk.sv
// Bench for hweval_mpadder_chk: two 8-bit harness instances driving behavioural adders;
// operand launches are checked against a scoreboard of expected {sub,a,b} triples.
module tb_hweval_mpadder_chk;
`ifdef HWEVAL_SIG_EN
  localparam bit SIG_ON = 1'b1;
`else
  localparam bit SIG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance 0: seeds 1/1/0, ITER=4; instance 1: seeds 3/5/1, ITER=1
  logic run0 = 1'b0, start0, sub0, done0, busy0, pass0, fail0, to0;
  logic [7:0] a0, b0;
  logic [8:0] res0;
  logic [15:0] err0;
  logic [31:0] sig0;
  logic run1 = 1'b0, start1, sub1, done1, busy1, pass1, fail1, to1;
  logic [7:0] a1, b1;
  logic [8:0] res1;
  logic [15:0] err1;
  logic [31:0] sig1;

  hweval_mpadder_chk #(.WIDTH(8), .ITER(4), .TIMEOUT(16),
                       .SEED_A(8'd1), .SEED_B(8'd1), .SEED_SUB(1'b0)) u_dut0 (
    .clk(clk), .resetn(resetn), .run(run0), .dut_start(start0), .dut_subtract(sub0),
    .dut_a(a0), .dut_b(b0), .dut_result(res0), .dut_done(done0), .busy(busy0),
    .pass(pass0), .fail(fail0), .timeout(to0), .err_count(err0), .sig(sig0));

  hweval_mpadder_chk #(.WIDTH(8), .ITER(1), .TIMEOUT(16),
                       .SEED_A(8'd3), .SEED_B(8'd5), .SEED_SUB(1'b1)) u_dut1 (
    .clk(clk), .resetn(resetn), .run(run1), .dut_start(start1), .dut_subtract(sub1),
    .dut_a(a1), .dut_b(b1), .dut_result(res1), .dut_done(done1), .busy(busy1),
    .pass(pass1), .fail(fail1), .timeout(to1), .err_count(err1), .sig(sig1));

  // behavioural adders under test: fixed latency, optional hang, optional result corruption
  int lat0 = 3, lat1 = 2, cnt0 = 0, cnt1 = 0;
  bit hang0 = 1'b0;
  logic [8:0] cmask0 = '0, cmask1 = '0;
  assign done0 = (cnt0 == 1);
  assign done1 = (cnt1 == 1);
  assign res0  = (sub0 ? ({1'b0, a0} - {1'b0, b0}) : ({1'b0, a0} + {1'b0, b0})) ^ cmask0;
  assign res1  = (sub1 ? ({1'b0, a1} - {1'b0, b1}) : ({1'b0, a1} + {1'b0, b1})) ^ cmask1;

  always @(posedge clk) begin
    if (!resetn)       cnt0 <= 0;
    else if (start0)   cnt0 <= hang0 ? 0 : lat0;
    else if (cnt0 > 0) cnt0 <= cnt0 - 1;
  end
  always @(posedge clk) begin
    if (!resetn)       cnt1 <= 0;
    else if (start1)   cnt1 <= lat1;
    else if (cnt1 > 0) cnt1 <= cnt1 - 1;
  end

  // scoreboard: expected {sub,a,b} at each dut_start
  logic [16:0] q0[$], q1[$];
  logic [16:0] e0, e1;
  logic [16:0] chain_tab [4] = '{17'h00101, 17'h00302, 17'h00705, 17'h0090C};

  always @(negedge clk) if (start0) begin
    checks++;
    if (q0.size() == 0) begin
      errors++;
      $display("FAIL launch0_unexpected got %h want no launch", {sub0, a0, b0});
    end else begin
      e0 = q0.pop_front();
      if ({sub0, a0, b0} !== e0) begin
        errors++;
        $display("FAIL launch0_operands got %h want %h", {sub0, a0, b0}, e0);
      end
    end
  end
  always @(negedge clk) if (start1) begin
    checks++;
    if (q1.size() == 0) begin
      errors++;
      $display("FAIL launch1_unexpected got %h want no launch", {sub1, a1, b1});
    end else begin
      e1 = q1.pop_front();
      if ({sub1, a1, b1} !== e1) begin
        errors++;
        $display("FAIL launch1_operands got %h want %h", {sub1, a1, b1}, e1);
      end
    end
  end

  task automatic push_chain0(input int k);
    for (int i = 0; i < k; i++) q0.push_back(chain_tab[i]);
  endtask

  task automatic pulse_run0();
    run0 = 1'b1; @(negedge clk); run0 = 1'b0;
  endtask

  task automatic pulse_run1();
    run1 = 1'b1; @(negedge clk); run1 = 1'b0;
  endtask

  task automatic count_busy0(output int n);
    n = 0;
    while (busy0 && n < 500) begin n++; @(negedge clk); end
  endtask

  task automatic count_busy1(output int n);
    n = 0;
    while (busy1 && n < 500) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy0, pass0, fail0, to0, start0, err0, sig0} !== '0) begin
      errors++;
      $display("FAIL reset0_outputs got %h want 0", {busy0, pass0, fail0, to0, start0, err0, sig0});
    end
    checks++;
    if ({sub0, a0, b0} !== 17'h00101) begin
      errors++; $display("FAIL reset0_seeds got %h want 00101", {sub0, a0, b0});
    end
    checks++;
    if ({busy1, pass1, fail1, to1, start1, err1, sig1} !== '0 || {sub1, a1, b1} !== 17'h10305) begin
      errors++; $display("FAIL reset1_state got %h/%h want 0/10305",
                         {busy1, pass1, fail1, to1, start1, err1, sig1}, {sub1, a1, b1});
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_chain();
    int n;
    lat0 = 3; push_chain0(4);
    pulse_run0();
    checks++;
    if (start0 !== 1'b1) begin errors++; $display("FAIL run_to_start got %b want 1", start0); end
    n = 0;
    while (busy0 && n < 500) begin
      n++;
      if (n == 6) begin
        checks++;
        if (sig0 !== (SIG_ON ? 32'h2 : 32'h0)) begin
          errors++; $display("FAIL sig_iter1 got %h want %h", sig0, SIG_ON ? 32'h2 : 32'h0);
        end
      end
      if (n == 11) begin
        checks++;
        if (sig0 !== (SIG_ON ? 32'h1 : 32'h0)) begin
          errors++; $display("FAIL sig_iter2 got %h want %h", sig0, SIG_ON ? 32'h1 : 32'h0);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 20) begin errors++; $display("FAIL chain_cycles got %0d want 20", n); end
    checks++;
    if ({pass0, fail0, to0, err0} !== {3'b100, 16'd0}) begin
      errors++; $display("FAIL chain_result got p%b f%b t%b e%0d want p1 f0 t0 e0", pass0, fail0, to0, err0);
    end
    checks++;
    if (sig0 !== (SIG_ON ? 32'h9 : 32'h0)) begin
      errors++; $display("FAIL chain_sig got %h want %h", sig0, SIG_ON ? 32'h9 : 32'h0);
    end
    // restart from END with single-cycle latency
    lat0 = 1; push_chain0(4);
    pulse_run0();
    checks++;
    if ({pass0, busy0} !== 2'b01) begin
      errors++; $display("FAIL restart_clears_pass got p%b b%b want p0 b1", pass0, busy0);
    end
    count_busy0(n);
    checks++;
    if (n !== 12 || pass0 !== 1'b1) begin
      errors++; $display("FAIL lat1_run got n%0d p%b want n12 p1", n, pass0);
    end
  endtask

  task automatic test_mismatch();
    int n;
    lat1 = 2; cmask1 = '0; q1.push_back(17'h10305);
    pulse_run1(); count_busy1(n);
    checks++;
    if (n !== 4 || {pass1, fail1, err1} !== {2'b10, 16'd0}) begin
      errors++; $display("FAIL sub_ok got n%0d p%b f%b e%0d want n4 p1 f0 e0", n, pass1, fail1, err1);
    end
    checks++;
    if (sig1 !== (SIG_ON ? 32'h1FE : 32'h0)) begin
      errors++; $display("FAIL sub_ok_sig got %h want %h", sig1, SIG_ON ? 32'h1FE : 32'h0);
    end
    cmask1 = 9'h100; q1.push_back(17'h10305);
    pulse_run1(); count_busy1(n);
    checks++;
    if ({pass1, fail1, to1, err1} !== {3'b010, 16'd1}) begin
      errors++; $display("FAIL sub_bad got p%b f%b t%b e%0d want p0 f1 t0 e1", pass1, fail1, to1, err1);
    end
    checks++;
    if (sig1 !== (SIG_ON ? 32'h0FE : 32'h0)) begin
      errors++; $display("FAIL sub_bad_sig got %h want %h", sig1, SIG_ON ? 32'h0FE : 32'h0);
    end
    cmask1 = '0;
    // every result wrong: sequence must still follow the golden chain
    lat0 = 2; cmask0 = 9'h001; push_chain0(4);
    pulse_run0(); count_busy0(n);
    checks++;
    if ({pass0, fail0, err0} !== {2'b01, 16'd4} || n !== 16) begin
      errors++; $display("FAIL all_bad got n%0d p%b f%b e%0d want n16 p0 f1 e4", n, pass0, fail0, err0);
    end
    cmask0 = '0;
  endtask

  task automatic test_timeout();
    int n;
    hang0 = 1'b1; q0.push_back(chain_tab[0]);
    pulse_run0(); count_busy0(n);
    checks++;
    if (n !== 17 || {to0, fail0, pass0, busy0} !== 4'b1100) begin
      errors++; $display("FAIL hang got n%0d t%b f%b p%b b%b want n17 t1 f1 p0 b0", n, to0, fail0, pass0, busy0);
    end
    // done on the last allowed WAIT cycle wins over the timeout
    hang0 = 1'b0; lat0 = 16; push_chain0(4);
    pulse_run0(); count_busy0(n);
    checks++;
    if (n !== 72 || {to0, pass0} !== 2'b01) begin
      errors++; $display("FAIL done_at_limit got n%0d t%b p%b want n72 t0 p1", n, to0, pass0);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    lat0 = 3; push_chain0(2);
    pulse_run0();
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy0, pass0, fail0, to0, start0, err0, sig0} !== '0 || {sub0, a0, b0} !== 17'h00101) begin
      errors++; $display("FAIL mid_reset got %h/%h want 0/00101",
                         {busy0, pass0, fail0, to0, start0, err0, sig0}, {sub0, a0, b0});
    end
    checks++;
    if (q0.size() !== 0) begin errors++; $display("FAIL mid_reset_launches got %0d left want 0", q0.size()); end
    resetn = 1'b1;
    push_chain0(4);
    pulse_run0(); count_busy0(n);
    checks++;
    if (n !== 20 || pass0 !== 1'b1) begin
      errors++; $display("FAIL post_reset_run got n%0d p%b want n20 p1", n, pass0);
    end
  endtask

  task automatic test_run_busy();
    int n;
    lat0 = 3; push_chain0(4);
    pulse_run0();
    n = 0;
    while (busy0 && n < 500) begin
      n++;
      run0 = (n == 3) || (n == 8) || (n == 15);
      @(negedge clk);
    end
    run0 = 1'b0;
    checks++;
    if (n !== 20 || pass0 !== 1'b1 || q0.size() !== 0) begin
      errors++; $display("FAIL run_while_busy got n%0d p%b q%0d want n20 p1 q0", n, pass0, q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_chain();
    test_mismatch();
    test_timeout();
    test_reset_mid();
    test_run_busy();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hweval_mpadder_chk.md
# hweval_mpadder_chk

Self-checking hardware-evaluation harness for the multi-precision adder family. It drives an external start/done adder DUT through a deterministic chained operand sequence for `ITER` operations and compares every DUT result against an internal golden model. It counts mismatches, detects DUT hangs with a timeout, and reports pass/fail. It sits on the FPGA evaluation top in place of the fixed-width single-flag harness, and connects to the adder under test port-for-port.

## Interface
- `WIDTH`, 514: operand width W; DUT result is W+1 bits.
- `ITER`, 1024: number of operations per run (≥1).
- `TIMEOUT`, 4096: maximum cycles in WAIT before a hang is declared (≥2).
- `SEED_A`, 1: initial `dut_a` (W bits).
- `SEED_B`, 1: initial `dut_b` (W bits).
- `SEED_SUB`, 0: initial `dut_subtract`.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `run` in 1: start-of-test pulse; ignored unless in IDLE or END.
- `dut_start` out 1: one-cycle start pulse to the DUT.
- `dut_subtract` out 1: 0 = add, 1 = subtract.
- `dut_a`, `dut_b` out W: operands, stable from `dut_start` until `dut_done`.
- `dut_result` in W+1: DUT result, sampled in the cycle `dut_done`=1.
- `dut_done` in 1: DUT completion.
- `busy` out 1: run in progress.
- `pass` out 1: last run completed with zero errors and no timeout.
- `fail` out 1: last run had ≥1 mismatch or a timeout.
- `timeout` out 1: last run aborted on a hang.
- `err_count` out 16: mismatches in the current/last run, saturating at 16'hFFFF.
- `sig` out 32: result signature (see Configuration).

## Operation
- States: IDLE, LAUNCH, WAIT, CHECK, END.
- IDLE/END + `run`=1 → LAUNCH:
  - load operands from seeds;
  - clear `err_count`, iteration counter, wait counter, `pass`/`fail`/`timeout`;
  - if compiled in, load `sig` = 32'h0.
- LAUNCH: `dut_start`=1 for exactly one cycle, then → WAIT.
- WAIT:
  - on `dut_done`=1, register `dut_result`, compute the golden value, → CHECK;
  - else increment the wait counter; when it reaches `TIMEOUT`, set `timeout`=1 and `fail`=1 → END.
- Golden model, (W+1)-bit modular arithmetic:
  - add: {1'b0,a} + {1'b0,b};
  - subtract: {1'b0,a} − {1'b0,b} mod 2^(W+1), so bit W is 1 iff a<b.
- CHECK:
  - if registered result ≠ golden, increment `err_count` (saturating);
  - update from the golden result g: a ← b ^ g[W−1:0], b ← g[W−1:0], subtract ← g[W]. Using the golden value keeps the sequence independent of DUT errors;
  - if iteration counter = `ITER`−1 → END, with `pass` = (`err_count`_next==0), `fail` = !`pass`;
  - else increment the iteration counter, clear the wait counter, → LAUNCH.
- END: outputs hold until the next `run` or reset.
- `dut_done` outside WAIT is ignored.

## Timing
- Reset (any state, including mid-run), all outputs 0:
  - `busy`, `pass`, `fail`, `timeout`, `dut_start`, `err_count`, `sig`;
  - `dut_a`=`SEED_A`, `dut_b`=`SEED_B`, `dut_subtract`=`SEED_SUB`;
  - state IDLE.
- `run` sampled at clock edge i → `dut_start`=1 in cycle i+1.
- Per iteration: 1 (LAUNCH) + DUT latency L (WAIT cycles up to and including `dut_done`) + 1 (CHECK).
- Total run: `ITER`·(L+2) cycles from the first `dut_start` to END entry.
- `busy`=1 from the cycle after `run` is accepted through the last CHECK cycle; 0 in IDLE and END.
- `dut_done` in the first WAIT cycle (L=1) is legal.
- Timeout fires on the `TIMEOUT`-th consecutive WAIT cycle without `dut_done`.
- `dut_done` and the timeout in the same cycle: `dut_done` wins.
- `run`=1 while busy: no effect.

## Configuration
- `HWEVAL_SIG_EN` defined:
  - in CHECK, `sig` ← {sig[30:0],sig[31]} ^ F, where F is the XOR of all 32-bit slices of the zero-padded DUT result;
  - this folds DUT results, including errors, for off-chip comparison.
- Undefined: no signature logic; `sig` is tied to 32'h0.

## Test plan
- W=8, seeds 1/1/0, ITER=4, DUT correct, L=3: DUT sees (1+1), (3+2), (7+5), (9+12); results 9'h002, 9'h005, 9'h00C, 9'h015; `pass`=1, `err_count`=0, END after 20 cycles.
- W=8, seeds 3/5/1, ITER=1: golden 9'h1FE; DUT returns 9'h1FE → `pass`=1. DUT returns 9'h0FE → `fail`=1, `err_count`=1.
- DUT never asserts `dut_done`, TIMEOUT=16: `timeout`=`fail`=1 and `busy`=0 after 16 WAIT cycles.
- `resetn`=0 during WAIT of iteration 2: next cycle IDLE, all outputs at reset values; a new `run` restarts from the seeds.
- `run` pulsed while busy: no restart, iteration count unaffected. `run` in END: clears `pass` and restarts.
- With `HWEVAL_SIG_EN`, W=8, seeds 1/1/0, ITER=2, DUT correct: `sig` = 32'h2 after iteration 1, then 32'h4^32'h5 = 32'h1 after iteration 2. Without the macro, `sig`=0 throughout.
